// File: rtl/regfile_writeback_if.sv
// Bundle of the write-back queue's source, register-file and scoreboard signals.
// The forwarding outputs exist only when WB_FORWARD_EN is defined.
interface regfile_writeback_if #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) ();
    localparam int CW = $clog2(DEPTH) + 1;

    logic              ld_valid_in;
    logic [ADDR_W-1:0] ld_addr_in;
    logic [DATA_W-1:0] ld_data_in;
    logic              alu_valid_in;
    logic [ADDR_W-1:0] alu_addr_in;
    logic [DATA_W-1:0] alu_data_in;
    logic              ready_out;
    logic              wr_en_out;
    logic [ADDR_W-1:0] wr_addr_out;
    logic [DATA_W-1:0] wr_data_out;
    logic [ADDR_W-1:0] chk_addrA_in;
    logic [ADDR_W-1:0] chk_addrB_in;
    logic              pendA_out;
    logic              pendB_out;
    logic [CW-1:0]     count_out;
    logic              overflow_out;
`ifdef WB_FORWARD_EN
    logic [DATA_W-1:0] fwdA_data_out;
    logic [DATA_W-1:0] fwdB_data_out;

    modport master (
        output ld_valid_in, ld_addr_in, ld_data_in,
        output alu_valid_in, alu_addr_in, alu_data_in,
        output chk_addrA_in, chk_addrB_in,
        input  ready_out, wr_en_out, wr_addr_out, wr_data_out,
        input  pendA_out, pendB_out, count_out, overflow_out,
        input  fwdA_data_out, fwdB_data_out
    );
    modport slave (
        input  ld_valid_in, ld_addr_in, ld_data_in,
        input  alu_valid_in, alu_addr_in, alu_data_in,
        input  chk_addrA_in, chk_addrB_in,
        output ready_out, wr_en_out, wr_addr_out, wr_data_out,
        output pendA_out, pendB_out, count_out, overflow_out,
        output fwdA_data_out, fwdB_data_out
    );
`else
    modport master (
        output ld_valid_in, ld_addr_in, ld_data_in,
        output alu_valid_in, alu_addr_in, alu_data_in,
        output chk_addrA_in, chk_addrB_in,
        input  ready_out, wr_en_out, wr_addr_out, wr_data_out,
        input  pendA_out, pendB_out, count_out, overflow_out
    );
    modport slave (
        input  ld_valid_in, ld_addr_in, ld_data_in,
        input  alu_valid_in, alu_addr_in, alu_data_in,
        input  chk_addrA_in, chk_addrB_in,
        output ready_out, wr_en_out, wr_addr_out, wr_data_out,
        output pendA_out, pendB_out, count_out, overflow_out
    );
`endif
endinterface

// File: rtl/regfile_writeback.sv
// In-order write-back FIFO (load + ALU sources) draining one entry per cycle into the
// register-file write port, with pending-write lookup. WB_FORWARD_EN adds youngest-value forwarding.
module regfile_writeback #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    regfile_writeback_if.slave   wb
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t            mem_q [DEPTH];
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, alu_slot;
    logic [CW-1:0]     count_q, count_d, free_w;
    logic              overflow_q;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [DATA_W-1:0] wr_data_q;
    logic              ld_acc, alu_acc, pop, drop;
    logic              pend_a, pend_b;

    // Free space is judged on the pre-edge count; a same-edge pop does not make room.
    always_comb begin
        free_w   = CW'(DEPTH) - count_q;
        ld_acc   = wb.ld_valid_in && (free_w != '0);
        alu_acc  = wb.alu_valid_in && (free_w > CW'(ld_acc));
        pop      = (count_q != '0);
        drop     = (wb.ld_valid_in && !ld_acc) || (wb.alu_valid_in && !alu_acc);
        alu_slot = ld_acc ? wr_ptr_q + PW'(1) : wr_ptr_q;
        wr_ptr_d = wr_ptr_q + PW'(ld_acc) + PW'(alu_acc);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q + CW'(ld_acc) + CW'(alu_acc) - CW'(pop);
    end

    // NOTE: FIFO storage has no reset; validity comes from the pointers and count alone,
    // so clearing the array would only add reset fan-out.
    always_ff @(posedge clk_in) begin
        if (ld_acc)  mem_q[wr_ptr_q] <= '{addr: wb.ld_addr_in,  data: wb.ld_data_in};
        if (alu_acc) mem_q[alu_slot] <= '{addr: wb.alu_addr_in, data: wb.alu_data_in};
    end

    // NOTE: all state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_q | drop;
            wr_en_q    <= pop;
            if (pop) begin
                wr_addr_q <= mem_q[rd_ptr_q].addr;
                wr_data_q <= mem_q[rd_ptr_q].data;
            end
        end
    end

    // NOTE: every always_comb output gets a default before the loop so no latch is inferred.
    always_comb begin
        pend_a = wr_en_q && (wr_addr_q == wb.chk_addrA_in);
        pend_b = wr_en_q && (wr_addr_q == wb.chk_addrB_in);
        for (int k = 0; k < DEPTH; k++) begin
            if (CW'(k) < count_q) begin
                if (mem_q[rd_ptr_q + PW'(k)].addr == wb.chk_addrA_in) pend_a = 1'b1;
                if (mem_q[rd_ptr_q + PW'(k)].addr == wb.chk_addrB_in) pend_b = 1'b1;
            end
        end
    end

`ifdef WB_FORWARD_EN
    logic [DATA_W-1:0] fwd_a, fwd_b;

    // Walk oldest to newest so the youngest match overwrites older ones.
    always_comb begin
        fwd_a = (wr_en_q && (wr_addr_q == wb.chk_addrA_in)) ? wr_data_q : '0;
        fwd_b = (wr_en_q && (wr_addr_q == wb.chk_addrB_in)) ? wr_data_q : '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (CW'(k) < count_q) begin
                if (mem_q[rd_ptr_q + PW'(k)].addr == wb.chk_addrA_in) fwd_a = mem_q[rd_ptr_q + PW'(k)].data;
                if (mem_q[rd_ptr_q + PW'(k)].addr == wb.chk_addrB_in) fwd_b = mem_q[rd_ptr_q + PW'(k)].data;
            end
        end
    end

    assign wb.fwdA_data_out = fwd_a;
    assign wb.fwdB_data_out = fwd_b;
`endif

    assign wb.ready_out    = (free_w >= CW'(2));
    assign wb.wr_en_out    = wr_en_q;
    assign wb.wr_addr_out  = wr_addr_q;
    assign wb.wr_data_out  = wr_data_q;
    assign wb.pendA_out    = pend_a;
    assign wb.pendB_out    = pend_b;
    assign wb.count_out    = count_q;
    assign wb.overflow_out = overflow_q;
endmodule

// File: tb/tb_regfile_writeback.sv
// Self-checking bench for regfile_writeback: directed scenarios plus randomized traffic
// checked against a queue-based model. Define WB_FORWARD_EN to also check forwarding.
module tb_regfile_writeback;
    localparam int DEPTH  = 4;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;
    localparam int CW     = $clog2(DEPTH) + 1;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_total = 0;
    int   n_pass  = 0;

    // Reference model: the queue contents plus the write-port registers.
    ent_t              mq[$];
    logic              m_wr_en;
    logic [ADDR_W-1:0] m_wr_addr;
    logic [DATA_W-1:0] m_wr_data;
    logic              m_ovf;

    regfile_writeback_if #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) wb ();

    regfile_writeback #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .wb       (wb)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic void model_reset();
        mq.delete();
        m_wr_en = 1'b0; m_wr_addr = '0; m_wr_data = '0; m_ovf = 1'b0;
    endfunction

    function automatic void model_step(input logic lv, input logic [ADDR_W-1:0] la, input logic [DATA_W-1:0] ld,
                                       input logic av, input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] ad);
        int   free;
        ent_t e;
        free = DEPTH - mq.size();
        if (mq.size() > 0) begin
            e = mq.pop_front();
            m_wr_en = 1'b1; m_wr_addr = e.addr; m_wr_data = e.data;
        end else begin
            m_wr_en = 1'b0;
        end
        if (lv) begin
            if (free >= 1) begin mq.push_back('{la, ld}); free--; end
            else m_ovf = 1'b1;
        end
        if (av) begin
            if (free >= 1) mq.push_back('{aa, ad});
            else m_ovf = 1'b1;
        end
    endfunction

    function automatic logic exp_pend(input logic [ADDR_W-1:0] a);
        logic hit = m_wr_en && (m_wr_addr == a);
        foreach (mq[i]) if (mq[i].addr == a) hit = 1'b1;
        return hit;
    endfunction

    function automatic logic [DATA_W-1:0] exp_fwd(input logic [ADDR_W-1:0] a);
        for (int i = mq.size() - 1; i >= 0; i--) if (mq[i].addr == a) return mq[i].data;
        if (m_wr_en && (m_wr_addr == a)) return m_wr_data;
        return '0;
    endfunction

    function automatic logic exp_ready();
        return (DEPTH - mq.size()) >= 2;
    endfunction

    // One clock: inputs applied at the falling edge, model advanced at the rising edge, outputs stable at +1.
    task automatic tick(input logic lv, input logic [ADDR_W-1:0] la, input logic [DATA_W-1:0] ld,
                        input logic av, input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] ad);
        @(negedge clk);
        wb.ld_valid_in = lv;  wb.ld_addr_in = la;  wb.ld_data_in = ld;
        wb.alu_valid_in = av; wb.alu_addr_in = aa; wb.alu_data_in = ad;
        @(posedge clk);
        model_step(lv, la, ld, av, aa, ad);
        #1;
        wb.ld_valid_in = 1'b0; wb.alu_valid_in = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic set_chk(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b);
        wb.chk_addrA_in = a; wb.chk_addrB_in = b;
        #1;
    endtask

    task automatic test_reset();
        wb.ld_valid_in = 1'b0; wb.alu_valid_in = 1'b0;
        wb.ld_addr_in = '0; wb.ld_data_in = '0; wb.alu_addr_in = '0; wb.alu_data_in = '0;
        wb.chk_addrA_in = 4'd3; wb.chk_addrB_in = 4'd0;
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_total++; if (wb.count_out !== '0)     $display("FAIL rst_count got %0d want 0", wb.count_out);     else n_pass++;
        n_total++; if (wb.wr_en_out !== 1'b0)   $display("FAIL rst_wr_en got %b want 0", wb.wr_en_out);      else n_pass++;
        n_total++; if (wb.wr_addr_out !== '0)   $display("FAIL rst_wr_addr got %0d want 0", wb.wr_addr_out); else n_pass++;
        n_total++; if (wb.wr_data_out !== '0)   $display("FAIL rst_wr_data got %h want 0", wb.wr_data_out);  else n_pass++;
        n_total++; if (wb.overflow_out !== 1'b0) $display("FAIL rst_ovf got %b want 0", wb.overflow_out);    else n_pass++;
        n_total++; if (wb.ready_out !== 1'b1)   $display("FAIL rst_ready got %b want 1", wb.ready_out);      else n_pass++;
        n_total++; if ({wb.pendA_out, wb.pendB_out} !== 2'b00)
            $display("FAIL rst_pend got %b%b want 00", wb.pendA_out, wb.pendB_out); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single_alu();
        set_chk(4'd3, 4'd7);
        tick(1'b0, '0, '0, 1'b1, 4'd3, 32'h11);
        n_total++; if (wb.pendA_out !== 1'b1) $display("FAIL single_pend_e1 got %b want 1", wb.pendA_out); else n_pass++;
        n_total++; if (wb.wr_en_out !== 1'b0) $display("FAIL single_wr_en_e1 got %b want 0", wb.wr_en_out); else n_pass++;
        n_total++; if (wb.count_out !== 3'd1) $display("FAIL single_count_e1 got %0d want 1", wb.count_out); else n_pass++;
        idle(1);
        n_total++; if ({wb.wr_en_out, wb.wr_addr_out, wb.wr_data_out} !== {1'b1, 4'd3, 32'h11})
            $display("FAIL single_write got en=%b addr=%0d data=%h want en=1 addr=3 data=11",
                     wb.wr_en_out, wb.wr_addr_out, wb.wr_data_out); else n_pass++;
        n_total++; if (wb.pendA_out !== 1'b1) $display("FAIL single_pend_e2 got %b want 1", wb.pendA_out); else n_pass++;
        n_total++; if (wb.pendB_out !== 1'b0) $display("FAIL single_pendB_e2 got %b want 0", wb.pendB_out); else n_pass++;
        idle(1);
        n_total++; if (wb.wr_en_out !== 1'b0) $display("FAIL single_wr_en_e3 got %b want 0", wb.wr_en_out); else n_pass++;
        n_total++; if (wb.pendA_out !== 1'b0) $display("FAIL single_pend_e3 got %b want 0", wb.pendA_out); else n_pass++;
        n_total++; if (wb.wr_data_out !== 32'h11) $display("FAIL single_hold got %h want 11", wb.wr_data_out); else n_pass++;
    endtask

    task automatic test_dual_push();
        set_chk(4'd1, 4'd2);
        tick(1'b1, 4'd1, 32'hAA, 1'b1, 4'd2, 32'hBB);
        n_total++; if (wb.count_out !== 3'd2) $display("FAIL dual_count0 got %0d want 2", wb.count_out); else n_pass++;
        idle(1);
        n_total++; if ({wb.wr_en_out, wb.wr_addr_out, wb.wr_data_out, wb.count_out} !== {1'b1, 4'd1, 32'hAA, 3'd1})
            $display("FAIL dual_first got en=%b addr=%0d data=%h cnt=%0d want 1/1/aa/1",
                     wb.wr_en_out, wb.wr_addr_out, wb.wr_data_out, wb.count_out); else n_pass++;
        idle(1);
        n_total++; if ({wb.wr_en_out, wb.wr_addr_out, wb.wr_data_out, wb.count_out} !== {1'b1, 4'd2, 32'hBB, 3'd0})
            $display("FAIL dual_second got en=%b addr=%0d data=%h cnt=%0d want 1/2/bb/0",
                     wb.wr_en_out, wb.wr_addr_out, wb.wr_data_out, wb.count_out); else n_pass++;
        n_total++; if ({wb.pendA_out, wb.pendB_out} !== 2'b01)
            $display("FAIL dual_pend got %b%b want 01", wb.pendA_out, wb.pendB_out); else n_pass++;
        idle(1);
    endtask

    task automatic test_forward();
        set_chk(4'd5, 4'd6);
        tick(1'b1, 4'd5, 32'h1, 1'b1, 4'd5, 32'h2);
        n_total++; if (wb.pendA_out !== 1'b1) $display("FAIL fwd_pend got %b want 1", wb.pendA_out); else n_pass++;
`ifdef WB_FORWARD_EN
        n_total++; if (wb.fwdA_data_out !== 32'h2) $display("FAIL fwd_both_queued got %h want 2", wb.fwdA_data_out); else n_pass++;
        n_total++; if (wb.fwdB_data_out !== 32'h0) $display("FAIL fwd_nomatch got %h want 0", wb.fwdB_data_out); else n_pass++;
`endif
        idle(1);
        n_total++; if ({wb.wr_addr_out, wb.wr_data_out} !== {4'd5, 32'h1})
            $display("FAIL fwd_order1 got addr=%0d data=%h want 5/1", wb.wr_addr_out, wb.wr_data_out); else n_pass++;
`ifdef WB_FORWARD_EN
        n_total++; if (wb.fwdA_data_out !== 32'h2) $display("FAIL fwd_one_queued got %h want 2", wb.fwdA_data_out); else n_pass++;
`endif
        idle(1);
        n_total++; if ({wb.wr_en_out, wb.wr_data_out} !== {1'b1, 32'h2})
            $display("FAIL fwd_order2 got en=%b data=%h want 1/2", wb.wr_en_out, wb.wr_data_out); else n_pass++;
`ifdef WB_FORWARD_EN
        n_total++; if (wb.fwdA_data_out !== 32'h2) $display("FAIL fwd_from_wr got %h want 2", wb.fwdA_data_out); else n_pass++;
`endif
        idle(1);
    endtask

    task automatic test_wrap();
        ent_t pushed[$];
        ent_t got;
        int   seen = 0;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        for (int i = 0; i < 10; i++) begin
            a = ADDR_W'($urandom);
            d = $urandom;
            pushed.push_back('{a, d});
            if (i % 2 == 0) tick(1'b1, a, d, 1'b0, '0, '0);
            else            tick(1'b0, '0, '0, 1'b1, a, d);
            if (wb.wr_en_out === 1'b1) begin
                got = pushed.pop_front();
                seen++;
                n_total++; if ({wb.wr_addr_out, wb.wr_data_out} !== {got.addr, got.data})
                    $display("FAIL wrap_seq%0d got %0d/%h want %0d/%h", seen, wb.wr_addr_out, wb.wr_data_out, got.addr, got.data);
                else n_pass++;
            end
            if (i % 3 == 2) begin
                idle(1);
                got = pushed.pop_front();
                seen++;
                n_total++; if ({wb.wr_en_out, wb.wr_addr_out, wb.wr_data_out} !== {1'b1, got.addr, got.data})
                    $display("FAIL wrap_seq%0d got %b/%0d/%h want 1/%0d/%h", seen, wb.wr_en_out, wb.wr_addr_out,
                             wb.wr_data_out, got.addr, got.data);
                else n_pass++;
            end
        end
        for (int c = 0; c < 2 * DEPTH && pushed.size() > 0; c++) begin
            idle(1);
            if (wb.wr_en_out === 1'b1) begin
                got = pushed.pop_front();
                seen++;
                n_total++; if ({wb.wr_addr_out, wb.wr_data_out} !== {got.addr, got.data})
                    $display("FAIL wrap_seq%0d got %0d/%h want %0d/%h", seen, wb.wr_addr_out, wb.wr_data_out, got.addr, got.data);
                else n_pass++;
            end
        end
        n_total++; if (seen != 10) $display("FAIL wrap_total got %0d writes want 10", seen); else n_pass++;
        idle(2);
    endtask

    task automatic test_fill_overflow();
        tick(1'b1, 4'd8, 32'h80, 1'b1, 4'd9, 32'h90);
        n_total++; if (wb.ready_out !== 1'b1) $display("FAIL fill_ready_c2 got %b want 1", wb.ready_out); else n_pass++;
        tick(1'b1, 4'd10, 32'hA0, 1'b1, 4'd11, 32'hB0);
        n_total++; if ({wb.count_out, wb.ready_out} !== {3'd3, 1'b0})
            $display("FAIL fill_full got cnt=%0d ready=%b want 3/0", wb.count_out, wb.ready_out); else n_pass++;
        n_total++; if (wb.overflow_out !== 1'b0) $display("FAIL fill_noovf got %b want 0", wb.overflow_out); else n_pass++;
        tick(1'b1, 4'd12, 32'hC0, 1'b1, 4'd13, 32'hD0);
        n_total++; if ({wb.overflow_out, wb.count_out} !== {1'b1, 3'd3})
            $display("FAIL fill_drop got ovf=%b cnt=%0d want 1/3", wb.overflow_out, wb.count_out); else n_pass++;
        set_chk(4'd12, 4'd13);
        n_total++; if ({wb.pendA_out, wb.pendB_out} !== 2'b10)
            $display("FAIL fill_kept_load got %b%b want 10", wb.pendA_out, wb.pendB_out); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            idle(1);
            n_total++; if ({wb.wr_en_out, wb.wr_addr_out, wb.wr_data_out} !== {m_wr_en, m_wr_addr, m_wr_data})
                $display("FAIL fill_drain%0d got %b/%0d/%h want %b/%0d/%h", i, wb.wr_en_out, wb.wr_addr_out,
                         wb.wr_data_out, m_wr_en, m_wr_addr, m_wr_data); else n_pass++;
        end
        n_total++; if ({wb.overflow_out, wb.count_out} !== {1'b1, 3'd0})
            $display("FAIL fill_sticky got ovf=%b cnt=%0d want 1/0", wb.overflow_out, wb.count_out); else n_pass++;
    endtask

    task automatic test_mid_reset();
        tick(1'b1, 4'd1, 32'h1, 1'b1, 4'd2, 32'h2);
        tick(1'b1, 4'd3, 32'h3, 1'b1, 4'd4, 32'h4);
        n_total++; if ({wb.count_out, wb.wr_en_out, wb.overflow_out} !== {3'd3, 1'b1, 1'b1})
            $display("FAIL midrst_pre got cnt=%0d en=%b ovf=%b want 3/1/1", wb.count_out, wb.wr_en_out, wb.overflow_out);
        else n_pass++;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_total++; if ({wb.count_out, wb.wr_en_out, wb.overflow_out} !== {3'd0, 1'b0, 1'b0})
            $display("FAIL midrst_async got cnt=%0d en=%b ovf=%b want 0/0/0", wb.count_out, wb.wr_en_out, wb.overflow_out);
        else n_pass++;
        n_total++; if ({wb.wr_addr_out, wb.wr_data_out} !== {4'd0, 32'd0})
            $display("FAIL midrst_wr got %0d/%h want 0/0", wb.wr_addr_out, wb.wr_data_out); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        logic lv, av;
        for (int i = 0; i < 400; i++) begin
            lv = ($urandom_range(0, 2) != 0);
            av = ($urandom_range(0, 1) != 0);
            if (!exp_ready() && $urandom_range(0, 15) != 0) begin lv = 1'b0; av = 1'b0; end
            tick(lv, ADDR_W'($urandom), $urandom, av, ADDR_W'($urandom), $urandom);
            set_chk(ADDR_W'($urandom), ADDR_W'($urandom));
            n_total++; if ({wb.count_out, wb.ready_out, wb.overflow_out} !== {CW'(mq.size()), exp_ready(), m_ovf})
                $display("FAIL rnd_state%0d got cnt=%0d rdy=%b ovf=%b want %0d/%b/%b", i, wb.count_out, wb.ready_out,
                         wb.overflow_out, mq.size(), exp_ready(), m_ovf); else n_pass++;
            n_total++; if ({wb.wr_en_out, wb.wr_addr_out, wb.wr_data_out} !== {m_wr_en, m_wr_addr, m_wr_data})
                $display("FAIL rnd_wr%0d got %b/%0d/%h want %b/%0d/%h", i, wb.wr_en_out, wb.wr_addr_out,
                         wb.wr_data_out, m_wr_en, m_wr_addr, m_wr_data); else n_pass++;
            n_total++; if ({wb.pendA_out, wb.pendB_out} !== {exp_pend(wb.chk_addrA_in), exp_pend(wb.chk_addrB_in)})
                $display("FAIL rnd_pend%0d got %b%b want %b%b", i, wb.pendA_out, wb.pendB_out,
                         exp_pend(wb.chk_addrA_in), exp_pend(wb.chk_addrB_in)); else n_pass++;
`ifdef WB_FORWARD_EN
            n_total++; if ({wb.fwdA_data_out, wb.fwdB_data_out} !== {exp_fwd(wb.chk_addrA_in), exp_fwd(wb.chk_addrB_in)})
                $display("FAIL rnd_fwd%0d got %h/%h want %h/%h", i, wb.fwdA_data_out, wb.fwdB_data_out,
                         exp_fwd(wb.chk_addrA_in), exp_fwd(wb.chk_addrB_in)); else n_pass++;
`endif
        end
    endtask

    initial begin
        test_reset();
        test_single_alu();
        test_dual_push();
        test_forward();
        test_wrap();
        test_fill_overflow();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
